// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the multi-port register file.
//   RF_DATA_W / RF_ADDR_W         default register width and select width
//   RF_MAX_DATA_W / RF_MAX_ADDR_W widest data/select the resolve helper handles
//   rf_wr_resolve()               per-address write-port resolution, port 1 wins
// ---------------------------------------------------------------------------
package rf_pkg;

   localparam int unsigned RF_DATA_W     = 16;
   localparam int unsigned RF_ADDR_W     = 3;
   localparam int unsigned RF_MAX_DATA_W = 64;
   localparam int unsigned RF_MAX_ADDR_W = 8;

   // Result layout: {hit, data}; data is zero when there is no hit.
   typedef logic [RF_MAX_DATA_W:0] rfWrRes_t;

   function automatic rfWrRes_t rf_wr_resolve(
      input logic                     we0,
      input logic [RF_MAX_ADDR_W-1:0] sel0,
      input logic [RF_MAX_DATA_W-1:0] d0,
      input logic                     we1,
      input logic [RF_MAX_ADDR_W-1:0] sel1,
      input logic [RF_MAX_DATA_W-1:0] d1,
      input logic [RF_MAX_ADDR_W-1:0] addr
   );
      rfWrRes_t res;
      res = '0;
      if (we0 && (sel0 == addr)) res = {1'b1, d0};
      // Evaluated last so the load-writeback port overrides the ALU port.
      if (we1 && (sel1 == addr)) res = {1'b1, d1};
      return res;
   endfunction

endpackage

// File: rtl/rf_read_port.sv
// ---------------------------------------------------------------------------
// rf_read_port
// One registered read port: address mux, optional write-to-read bypass and
// the data/busy output registers.
//   clk, rst, en           clock, async active-high reset, global enable
//   regFile, busyNow       current storage and scoreboard
//   busyNext               scoreboard value after this edge (bypass view)
//   we0/selD0/dataD0       write port 0
//   we1/selD1/dataD1       write port 1
//   sel                    read address
//   dataQ, busyQ           registered read data and busy flag
// ---------------------------------------------------------------------------
module rf_read_port
   import rf_pkg::*;
#(
   parameter int unsigned DATA_W   = RF_DATA_W,
   parameter int unsigned ADDR_W   = RF_ADDR_W,
   parameter bit          BYPASS   = 1'b1,
   parameter bit          ZERO_REG = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [DATA_W-1:0]      regFile [2**ADDR_W],
   input  logic [2**ADDR_W-1:0]   busyNow,
   input  logic [2**ADDR_W-1:0]   busyNext,
   input  logic                   we0,
   input  logic [ADDR_W-1:0]      selD0,
   input  logic [DATA_W-1:0]      dataD0,
   input  logic                   we1,
   input  logic [ADDR_W-1:0]      selD1,
   input  logic [DATA_W-1:0]      dataD1,
   input  logic [ADDR_W-1:0]      sel,
   output logic [DATA_W-1:0]      dataQ,
   output logic                   busyQ
);

   logic [DATA_W-1:0] dataD;
   logic              busyD;

   function automatic rfWrRes_t resolveAt(input logic [ADDR_W-1:0] addr);
      return rf_wr_resolve(we0, RF_MAX_ADDR_W'(selD0), RF_MAX_DATA_W'(dataD0),
                           we1, RF_MAX_ADDR_W'(selD1), RF_MAX_DATA_W'(dataD1),
                           RF_MAX_ADDR_W'(addr));
   endfunction

   always_comb begin
      dataD = regFile[sel];
      busyD = busyNow[sel];
      if (BYPASS) begin
         if (1'(resolveAt(sel) >> RF_MAX_DATA_W)) dataD = DATA_W'(resolveAt(sel));
         busyD = busyNext[sel];
      end
      // The bypass path would otherwise leak a discarded R0 write.
      if (ZERO_REG && (sel == '0)) begin
         dataD = '0;
         busyD = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dataQ <= '0;
         busyQ <= 1'b0;
      end else if (en) begin
         dataQ <= dataD;
         busyQ <= busyD;
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
// Parametrised register file: two write ports (ALU, load writeback), two
// registered read ports, optional bypass, optional hardwired-zero R0 and a
// per-register busy scoreboard for decode stalls.
//   I_clk, I_rst, I_en         clock, async active-high reset, global enable
//   I_we0/I_selD0/I_dataD0     write port 0 (ALU)
//   I_we1/I_selD1/I_dataD1     write port 1 (load writeback, wins conflicts)
//   I_selA, I_selB             read addresses
//   I_resv, I_selR             reserve request marking I_selR busy
//   O_dataA/B, O_busyA/B       registered read data and busy flags
// ---------------------------------------------------------------------------
module reg_file_mp
   import rf_pkg::*;
#(
   parameter int unsigned DATA_W   = RF_DATA_W,
   parameter int unsigned ADDR_W   = RF_ADDR_W,
   parameter bit          BYPASS   = 1'b1,
   parameter bit          ZERO_REG = 1'b0
) (
   input  logic              I_clk,
   input  logic              I_rst,
   input  logic              I_en,
   input  logic              I_we0,
   input  logic [ADDR_W-1:0] I_selD0,
   input  logic [DATA_W-1:0] I_dataD0,
   input  logic              I_we1,
   input  logic [ADDR_W-1:0] I_selD1,
   input  logic [DATA_W-1:0] I_dataD1,
   input  logic [ADDR_W-1:0] I_selA,
   input  logic [ADDR_W-1:0] I_selB,
   input  logic              I_resv,
   input  logic [ADDR_W-1:0] I_selR,
   output logic [DATA_W-1:0] O_dataA,
   output logic [DATA_W-1:0] O_dataB,
   output logic              O_busyA,
   output logic              O_busyB
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] regs     [DEPTH];
   logic [DATA_W-1:0] regsNext [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busyNext;

   function automatic rfWrRes_t resolveAt(input logic [ADDR_W-1:0] addr);
      return rf_wr_resolve(I_we0, RF_MAX_ADDR_W'(I_selD0), RF_MAX_DATA_W'(I_dataD0),
                           I_we1, RF_MAX_ADDR_W'(I_selD1), RF_MAX_DATA_W'(I_dataD1),
                           RF_MAX_ADDR_W'(addr));
   endfunction

   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         regsNext[i] = regs[i];
         busyNext[i] = busy[i];
         if (!(ZERO_REG && (i == 0))) begin
            if (1'(resolveAt(ADDR_W'(i)) >> RF_MAX_DATA_W)) begin
               regsNext[i] = DATA_W'(resolveAt(ADDR_W'(i)));
               busyNext[i] = 1'b0;
            end
            // Applied after the write clear: a new reservation outranks the
            // producer completing in the same cycle.
            if (I_resv && (I_selR == ADDR_W'(i))) busyNext[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
         busy <= '0;
      end else if (I_en) begin
         regs <= regsNext;
         busy <= busyNext;
      end
   end

   rf_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .BYPASS  (BYPASS),
      .ZERO_REG(ZERO_REG)
   ) portA (
      .clk     (I_clk),
      .rst     (I_rst),
      .en      (I_en),
      .regFile (regs),
      .busyNow (busy),
      .busyNext(busyNext),
      .we0     (I_we0),
      .selD0   (I_selD0),
      .dataD0  (I_dataD0),
      .we1     (I_we1),
      .selD1   (I_selD1),
      .dataD1  (I_dataD1),
      .sel     (I_selA),
      .dataQ   (O_dataA),
      .busyQ   (O_busyA)
   );

   rf_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .BYPASS  (BYPASS),
      .ZERO_REG(ZERO_REG)
   ) portB (
      .clk     (I_clk),
      .rst     (I_rst),
      .en      (I_en),
      .regFile (regs),
      .busyNow (busy),
      .busyNext(busyNext),
      .we0     (I_we0),
      .selD0   (I_selD0),
      .dataD0  (I_dataD0),
      .we1     (I_we1),
      .selD1   (I_selD1),
      .dataD1  (I_dataD1),
      .sel     (I_selB),
      .dataQ   (O_dataB),
      .busyQ   (O_busyB)
   );

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

   localparam int N = 8;

   logic        clk = 1'b0;
   logic        rst, en, we0, we1, resv;
   logic [2:0]  selD0, selD1, selA, selB, selR;
   logic [15:0] dataD0, dataD1;

   // Flavour 0: defaults (BYPASS=1, ZERO_REG=0). Flavour 1: BYPASS=0, ZERO_REG=1.
   logic [15:0] oDataA [2], oDataB [2];
   logic        oBusyA [2], oBusyB [2];

   int total = 0;
   int bad   = 0;
   string curTag = "reset";

   // Reference state per flavour.
   logic [15:0] mReg  [2][N];
   logic        mBusy [2][N];
   logic [15:0] eDataA [2], eDataB [2];
   logic        eBusyA [2], eBusyB [2];

   always #5 clk = ~clk;

   reg_file_mp dut (
      .I_clk(clk), .I_rst(rst), .I_en(en),
      .I_we0(we0), .I_selD0(selD0), .I_dataD0(dataD0),
      .I_we1(we1), .I_selD1(selD1), .I_dataD1(dataD1),
      .I_selA(selA), .I_selB(selB), .I_resv(resv), .I_selR(selR),
      .O_dataA(oDataA[0]), .O_dataB(oDataB[0]), .O_busyA(oBusyA[0]), .O_busyB(oBusyB[0])
   );

   reg_file_mp #(.BYPASS(1'b0), .ZERO_REG(1'b1)) dutZ (
      .I_clk(clk), .I_rst(rst), .I_en(en),
      .I_we0(we0), .I_selD0(selD0), .I_dataD0(dataD0),
      .I_we1(we1), .I_selD1(selD1), .I_dataD1(dataD1),
      .I_selA(selA), .I_selB(selB), .I_resv(resv), .I_selR(selR),
      .O_dataA(oDataA[1]), .O_dataB(oDataB[1]), .O_busyA(oBusyA[1]), .O_busyB(oBusyB[1])
   );

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < N; i++) begin
            mReg[k][i]  = 16'h0;
            mBusy[k][i] = 1'b0;
         end
         eDataA[k] = 16'h0; eDataB[k] = 16'h0;
         eBusyA[k] = 1'b0;  eBusyB[k] = 1'b0;
      end
   endtask

   // One rising edge of the reference: sequential write semantics, port 1
   // applied after port 0, reservations applied after write clears.
   task automatic modelEdge();
      logic [15:0] preR [N];
      logic        preB [N];
      bit          byp, zr;
      if (rst) begin
         modelReset();
         return;
      end
      if (!en) return;
      for (int k = 0; k < 2; k++) begin
         byp = (k == 0);
         zr  = (k == 1);
         preR = mReg[k];
         preB = mBusy[k];
         if (we0 && !(zr && selD0 == 0)) begin mReg[k][selD0] = dataD0; mBusy[k][selD0] = 1'b0; end
         if (we1 && !(zr && selD1 == 0)) begin mReg[k][selD1] = dataD1; mBusy[k][selD1] = 1'b0; end
         if (resv && !(zr && selR == 0)) mBusy[k][selR] = 1'b1;
         eDataA[k] = byp ? mReg[k][selA]  : preR[selA];
         eDataB[k] = byp ? mReg[k][selB]  : preR[selB];
         eBusyA[k] = byp ? mBusy[k][selA] : preB[selA];
         eBusyB[k] = byp ? mBusy[k][selB] : preB[selB];
      end
   endtask

   task automatic checkAll();
      for (int k = 0; k < 2; k++) begin
         checkEq($sformatf("%s.f%0d.dataA", curTag, k), 32'(oDataA[k]), 32'(eDataA[k]));
         checkEq($sformatf("%s.f%0d.dataB", curTag, k), 32'(oDataB[k]), 32'(eDataB[k]));
         checkEq($sformatf("%s.f%0d.busyA", curTag, k), 32'(oBusyA[k]), 32'(eBusyA[k]));
         checkEq($sformatf("%s.f%0d.busyB", curTag, k), 32'(oBusyB[k]), 32'(eBusyB[k]));
      end
   endtask

   // Inputs are driven after a falling edge; this clocks one edge, checks,
   // and returns at the next falling edge.
   task automatic tick();
      @(posedge clk);
      modelEdge();
      #1;
      checkAll();
      @(negedge clk);
   endtask

   task automatic idle();
      en = 1'b1; we0 = 1'b0; we1 = 1'b0; resv = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; we0 = 1'b0; we1 = 1'b0; resv = 1'b0;
      selD0 = '0; selD1 = '0; selA = '0; selB = '0; selR = '0;
      dataD0 = '0; dataD1 = '0;
      modelReset();
      @(negedge clk); @(negedge clk);
      checkAll();
      rst = 1'b0;

      // Read every address after reset.
      curTag = "rdall";
      idle();
      for (int a = 0; a < N; a++) begin
         selA = 3'(a); selB = 3'(N - 1 - a);
         tick();
         checkEq("rdall.zero", 32'(oDataA[0]), 32'h0);
      end

      // Basic write, then enable freeze.
      curTag = "wr";
      we0 = 1'b1; selD0 = 3'd2; dataD0 = 16'h2222; selA = 3'd2; selB = 3'd1;
      tick();
      checkEq("wr.bypass", 32'(oDataA[0]), 32'h2222);
      idle(); tick();
      checkEq("wr.readA", 32'(oDataA[0]), 32'h2222);
      checkEq("wr.readZ", 32'(oDataA[1]), 32'h2222);
      checkEq("wr.readB", 32'(oDataB[0]), 32'h0);
      en = 1'b0; we0 = 1'b1; dataD0 = 16'h3333; selA = 3'd5;
      tick();
      checkEq("freeze.out", 32'(oDataA[0]), 32'h2222);
      idle(); selA = 3'd2; tick();
      checkEq("freeze.reg", 32'(oDataA[0]), 32'h2222);

      // Same-address dual write.
      curTag = "conflict";
      we0 = 1'b1; selD0 = 3'd4; dataD0 = 16'hAAAA;
      we1 = 1'b1; selD1 = 3'd4; dataD1 = 16'h4444; selA = 3'd4;
      tick();
      checkEq("conflict.byp", 32'(oDataA[0]), 32'h4444);
      checkEq("conflict.nobyp", 32'(oDataA[1]), 32'h0);
      idle(); tick();
      checkEq("conflict.after", 32'(oDataA[1]), 32'h4444);

      // Scoreboard.
      curTag = "busy";
      resv = 1'b1; selR = 3'd5; selA = 3'd5;
      tick();
      checkEq("busy.set.byp", 32'(oBusyA[0]), 32'h1);
      checkEq("busy.set.nobyp", 32'(oBusyA[1]), 32'h0);
      idle(); tick();
      we1 = 1'b1; selD1 = 3'd5; dataD1 = 16'h5555;
      tick();
      checkEq("busy.clr", 32'(oBusyA[0]), 32'h0);
      checkEq("busy.data", 32'(oDataA[0]), 32'h5555);
      idle();
      resv = 1'b1; selR = 3'd5; we0 = 1'b1; selD0 = 3'd5; dataD0 = 16'h1234;
      tick();
      idle(); tick();
      checkEq("busy.resvwins", 32'(oBusyA[1]), 32'h1);
      checkEq("busy.resvdata", 32'(oDataA[1]), 32'h1234);

      // Hardwired zero.
      curTag = "zero";
      we0 = 1'b1; selD0 = 3'd0; dataD0 = 16'hFFFF; resv = 1'b1; selR = 3'd0;
      selA = 3'd0; selB = 3'd0;
      tick();
      idle(); tick();
      checkEq("zero.data", 32'(oDataA[1]), 32'h0);
      checkEq("zero.busy", 32'(oBusyB[1]), 32'h0);

      // Async reset during a write to a busy register.
      curTag = "rstmid";
      resv = 1'b1; selR = 3'd3; tick();
      idle();
      we0 = 1'b1; selD0 = 3'd3; dataD0 = 16'hFEED; selA = 3'd3; selB = 3'd3;
      #2 rst = 1'b1;
      #1 modelReset();
      checkAll();
      tick();
      rst = 1'b0; idle();
      tick();
      checkEq("rstmid.data", 32'(oDataA[0]), 32'h0);
      checkEq("rstmid.busy", 32'(oBusyA[0]), 32'h0);

      // Randomized traffic.
      curTag = "rand";
      for (int c = 0; c < 800; c++) begin
         rst    = ($urandom_range(0, 99) == 0);
         en     = ($urandom_range(0, 7) != 0);
         we0    = 1'($urandom);
         we1    = 1'($urandom);
         resv   = ($urandom_range(0, 3) == 0);
         selD0  = 3'($urandom); selD1 = 3'($urandom);
         // Bias toward conflicts on one write address.
         if ($urandom_range(0, 3) == 0) selD1 = selD0;
         selR   = 3'($urandom);
         if ($urandom_range(0, 3) == 0) selR = selD0;
         selA   = 3'($urandom); selB = 3'($urandom);
         dataD0 = 16'($urandom); dataD1 = 16'($urandom);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
